fpu_wb_arbiter: RTL

//  Write side of the FP register file: arbitrates FP results between the multi-cycle FPU and the FLW load path.

---
 rtl/fpu_wb_arbiter_pkg.sv | 49 ++++
 rtl/fp_scoreboard.sv | 61 ++++++
 rtl/fpu_wb_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/fpu_wb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// fpu_wb_arbiter_pkg
//   Shared widths, exception-flag bit positions and helper types for the FP
//   register-file write side (fpu_wb_arbiter and fp_scoreboard).
//
//   XLEN      : FP data width
//   LOG2_FRF  : FP register index width, NUM_FREG = 2**LOG2_FRF registers
//   FFLAGS_W  : width of the IEEE exception flag vector {NV,DZ,OF,UF,NX}
// ---------------------------------------------------------------------------
package fpu_wb_arbiter_pkg;

    localparam int XLEN           = 32;
    localparam int LOG2_FRF       = 5;
    localparam int NUM_FREG       = 1 << LOG2_FRF;
    localparam int STARVE_LIM_DEF = 4;

    // fflags layout, LSB first: NX, UF, OF, DZ, NV.
    localparam int FFLAGS_W = 5;
    localparam int FFLAG_NX = 0;
    localparam int FFLAG_UF = 1;
    localparam int FFLAG_OF = 2;
    localparam int FFLAG_DZ = 3;
    localparam int FFLAG_NV = 4;

    // Which source owns the write port in the current cycle.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_LD   = 2'd1,
        SRC_FPU  = 2'd2
    } wb_src_e;

    // One register-file write request.
    typedef struct packed {
        logic [LOG2_FRF-1:0] rd;
        logic [XLEN-1:0]     data;
    } wb_req_t;

    // One-hot decode of a register index, all-zero when not enabled.
    function automatic logic [NUM_FREG-1:0] reg_onehot(input logic                en,
                                                       input logic [LOG2_FRF-1:0] idx);
        logic [NUM_FREG-1:0] v;
        v = '0;
        if (en) begin
            v[idx] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/fp_scoreboard.sv
// ---------------------------------------------------------------------------
// fp_scoreboard
//   Pending-write bit per FP register. A bit is set when an FP-writing
//   instruction issues to that register and cleared when the register file
//   write for it happens. Three combinational read ports let the issue stage
//   probe its source operands.
//
//   clk, rst_n           : clock, async active-low reset (all bits clear)
//   set_en / set_idx     : mark set_idx pending at the next edge
//   clr_en / clr_idx     : clear clr_idx at the next edge
//   rd_idx1..3           : probed register indices
//   rd_busy1..3          : probed register has a pending write
//
//   A set and clear of the same index in one cycle leaves the bit set: the
//   newly issued instruction still owes a write. Setting an already set bit
//   is idempotent; there is no per-register counting.
// ---------------------------------------------------------------------------
module fp_scoreboard
    import fpu_wb_arbiter_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                set_en,
    input  logic [LOG2_FRF-1:0] set_idx,
    input  logic                clr_en,
    input  logic [LOG2_FRF-1:0] clr_idx,
    input  logic [LOG2_FRF-1:0] rd_idx1,
    input  logic [LOG2_FRF-1:0] rd_idx2,
    input  logic [LOG2_FRF-1:0] rd_idx3,
    output logic                rd_busy1,
    output logic                rd_busy2,
    output logic                rd_busy3
);

    logic [NUM_FREG-1:0] busy;
    logic [NUM_FREG-1:0] set_mask;
    logic [NUM_FREG-1:0] clr_mask;
    logic [NUM_FREG-1:0] busy_next;

    always_comb begin
        set_mask  = reg_onehot(set_en, set_idx);
        clr_mask  = reg_onehot(clr_en, clr_idx);
        // Clear first, then set, so a simultaneous set on the same index wins.
        busy_next = (busy & ~clr_mask) | set_mask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // Reads come from the registered vector only; a write landing this
    // cycle is not visible until the following cycle.
    assign rd_busy1 = busy[rd_idx1];
    assign rd_busy2 = busy[rd_idx2];
    assign rd_busy3 = busy[rd_idx3];

endmodule

// File: rtl/fpu_wb_arbiter.sv
// ---------------------------------------------------------------------------
// fpu_wb_arbiter
//   Write side of the FP register file. Arbitrates between FPU results and
//   FLW load data for the single registered write port, tracks pending
//   writes per register for hazard stalls, and accumulates sticky fflags.
//
//   clk, rst_n                      : clock, async active-low reset
//   fpu_valid/fpu_ready             : FPU result handshake
//   fpu_rd, fpu_data, fpu_fflags    : FPU destination, result, flags
//   ld_valid/ld_ready               : FLW data handshake
//   ld_rd, ld_data                  : FLW destination and data
//   iss_valid, iss_rd               : FP-writing issue marks iss_rd pending
//   chk_rs1..3 / rs1..3_busy        : scoreboard probes for the issue stage
//   FRegWrite, wb_rd, wb_data       : registered register-file write port
//   fflags, fflags_clr              : sticky exception flags, CSR clear
//
// Handshake: a source presents *_valid with its payload held stable until it
// sees *_ready high in the same cycle; that cycle is the transfer. *_ready is
// a combinational grant computed from both valids and the starvation counter
// only, never from the other ready, so there is no combinational loop. At
// most one ready is high per cycle, and the write port never back-pressures.
//
// Priority is load over FPU. The FPU is forced through once it has lost
// STARVE_LIM consecutive contended cycles, so a waiting FPU result is always
// written eventually even under a continuous load stream.
// ---------------------------------------------------------------------------
module fpu_wb_arbiter
    import fpu_wb_arbiter_pkg::*;
#(
    parameter int STARVE_LIM = STARVE_LIM_DEF
)
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                fpu_valid,
    output logic                fpu_ready,
    input  logic [LOG2_FRF-1:0] fpu_rd,
    input  logic [XLEN-1:0]     fpu_data,
    input  logic [FFLAGS_W-1:0] fpu_fflags,
    input  logic                ld_valid,
    output logic                ld_ready,
    input  logic [LOG2_FRF-1:0] ld_rd,
    input  logic [XLEN-1:0]     ld_data,
    input  logic                iss_valid,
    input  logic [LOG2_FRF-1:0] iss_rd,
    input  logic [LOG2_FRF-1:0] chk_rs1,
    input  logic [LOG2_FRF-1:0] chk_rs2,
    input  logic [LOG2_FRF-1:0] chk_rs3,
    output logic                rs1_busy,
    output logic                rs2_busy,
    output logic                rs3_busy,
    output logic                FRegWrite,
    output logic [LOG2_FRF-1:0] wb_rd,
    output logic [XLEN-1:0]     wb_data,
    output logic [FFLAGS_W-1:0] fflags,
    input  logic                fflags_clr
);

    localparam int              CNT_W   = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIM);

    logic [CNT_W-1:0] starve_cnt;
    logic             fpu_forced;
    wb_src_e          grant_src;
    wb_req_t          win_req;

    // ------------------------------------------------------------------
    // Grant
    // ------------------------------------------------------------------
    always_comb begin
        fpu_forced = fpu_valid && (starve_cnt == CNT_MAX);
        grant_src  = SRC_NONE;
        if (ld_valid && !fpu_forced) begin
            grant_src = SRC_LD;
        end else if (fpu_valid) begin
            grant_src = SRC_FPU;
        end
    end

    assign ld_ready  = (grant_src == SRC_LD);
    assign fpu_ready = (grant_src == SRC_FPU);

    always_comb begin
        win_req.rd   = ld_rd;
        win_req.data = ld_data;
        if (grant_src == SRC_FPU) begin
            win_req.rd   = fpu_rd;
            win_req.data = fpu_data;
        end
    end

    // ------------------------------------------------------------------
    // Starvation counter, write register, sticky flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            FRegWrite  <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
            fflags     <= '0;
        end else begin
            // Counts only cycles where the FPU waited behind a load; any
            // cycle without an FPU request ends the losing streak.
            if (!fpu_valid || (grant_src == SRC_FPU)) begin
                starve_cnt <= '0;
            end else if ((grant_src == SRC_LD) && (starve_cnt != CNT_MAX)) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end

            // Write strobe is a single-cycle pulse; index/data hold when idle.
            FRegWrite <= (grant_src != SRC_NONE);
            if (grant_src != SRC_NONE) begin
                wb_rd   <= win_req.rd;
                wb_data <= win_req.data;
            end

            // A CSR clear arriving with an FPU grant clears the old flags but
            // keeps the new result's flags.
            if (grant_src == SRC_FPU) begin
                fflags <= (fflags_clr ? '0 : fflags) | fpu_fflags;
            end else if (fflags_clr) begin
                fflags <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pending-write scoreboard, cleared by the write actually leaving
    // the write register.
    // ------------------------------------------------------------------
    fp_scoreboard u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (iss_valid),
        .set_idx  (iss_rd),
        .clr_en   (FRegWrite),
        .clr_idx  (wb_rd),
        .rd_idx1  (chk_rs1),
        .rd_idx2  (chk_rs2),
        .rd_idx3  (chk_rs3),
        .rd_busy1 (rs1_busy),
        .rd_busy2 (rs2_busy),
        .rd_busy3 (rs3_busy)
    );

endmodule
